// File: rtl/line_miss_sched_if.sv
// Fetch-engine command bus between the miss scheduler and the line fetch engine.
// master (scheduler): drives fetch_req / fetch_cmd / fetch_tag / fetch_addr,
//                     samples fetch_gnt (command accepted) and fetch_done (command finished).
// slave  (engine)   : the mirror image.
interface line_miss_sched_if #(
    parameter int addr_width = 32,
    parameter int list_depth = 4
);
    logic                          fetch_req;
    logic [1:0]                    fetch_cmd;
    logic [$clog2(list_depth)-1:0] fetch_tag;
    logic [addr_width-1:0]         fetch_addr;
    logic                          fetch_gnt;
    logic                          fetch_done;

    modport master (
        output fetch_req,
        output fetch_cmd,
        output fetch_tag,
        output fetch_addr,
        input  fetch_gnt,
        input  fetch_done
    );

    modport slave (
        input  fetch_req,
        input  fetch_cmd,
        input  fetch_tag,
        input  fetch_addr,
        output fetch_gnt,
        output fetch_done
    );
endinterface

// File: rtl/line_miss_sched.sv
// Miss scheduler: arbitrates two requesters round-robin, looks the missing line up
// in the line table, picks a FIFO victim, sequences an optional writeback and a
// refill on the fetch engine, then returns the line tag to the owner.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   miss_req_x / miss_addr_x   miss request (held until granted) and its address
//   miss_gnt_x                 combinational grant, only asserted in IDLE
//   miss_done_x / miss_tag     one-cycle completion pulse and assigned line tag
//   dirty_set / dirty_tag      cache write hit marks a valid line dirty
//   line_valid, busy           per-line valid vector, scheduler not idle
//   fetch_bus                  command bus to the line fetch engine
module line_miss_sched #(
    parameter int addr_width = 32,
    parameter int list_depth = 4,
    parameter int list_width = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          miss_req_0,
    input  logic                          miss_req_1,
    input  logic [addr_width-1:0]         miss_addr_0,
    input  logic [addr_width-1:0]         miss_addr_1,
    output logic                          miss_gnt_0,
    output logic                          miss_gnt_1,
    output logic                          miss_done_0,
    output logic                          miss_done_1,
    output logic [$clog2(list_depth)-1:0] miss_tag,
    input  logic                          dirty_set,
    input  logic [$clog2(list_depth)-1:0] dirty_tag,
    output logic [list_depth-1:0]         line_valid,
    output logic                          busy,
    line_miss_sched_if.master             fetch_bus
);
    localparam int TW = $clog2(list_depth);
    localparam int OW = $clog2(list_width);
    localparam int LW = addr_width - OW;
    localparam logic [TW-1:0] LAST_TAG = TW'(list_depth - 1);
    localparam logic [1:0] CMD_WB = 2'b00;
    localparam logic [1:0] CMD_RF = 2'b01;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        WB_REQ  = 3'd2,
        WB_WAIT = 3'd3,
        RF_REQ  = 3'd4,
        RF_WAIT = 3'd5,
        RESP    = 3'd6
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;

    // line table
    logic [list_depth-1:0] valid_r;
    logic [list_depth-1:0] dirty_r;
    logic [LW-1:0]         line_tab_r [list_depth];
    logic [TW-1:0]         victim_ptr_r;

    // current miss context
    logic [LW-1:0]         cur_line_r;
    logic [TW-1:0]         cur_tag_r;
    logic                  owner_r;
    logic                  rr_ptr_r;

    // decode
    logic                  any_req_s;
    logic                  win_s;
    logic                  hit_s;
    logic [TW-1:0]         hit_idx_s;
    logic [TW-1:0]         check_tag_s;
    logic [TW-1:0]         tag_nxt_s;
    logic                  victim_dirty_s;
    logic                  in_fetch_s;
    logic                  dirty_ok_s;

    // next output values and their registers
    logic                  fetch_req_s, fetch_req_r;
    logic [1:0]            fetch_cmd_s, fetch_cmd_r;
    logic [TW-1:0]         fetch_tag_s, fetch_tag_r;
    logic [addr_width-1:0] fetch_addr_s, fetch_addr_r;
    logic                  done_0_s, done_0_r;
    logic                  done_1_s, done_1_r;
    logic [TW-1:0]         miss_tag_s, miss_tag_r;
    logic                  busy_s, busy_r;

    // The word-offset bits of the miss address never reach the line table.
    logic                  unused_addr_bits_s;
    assign unused_addr_bits_s = ^{miss_addr_0[OW-1:0], miss_addr_1[OW-1:0]};

    // Round-robin winner, line lookup and victim selection
    always_comb begin
        any_req_s = miss_req_0 | miss_req_1;
        if (miss_req_0 && miss_req_1) begin
            win_s = rr_ptr_r;
        end else if (miss_req_1) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end

        hit_s     = 1'b0;
        hit_idx_s = {TW{1'b0}};
        for (int i = 0; i < list_depth; i++) begin
            if (!hit_s && valid_r[i] && (line_tab_r[i] == cur_line_r)) begin
                hit_s     = 1'b1;
                hit_idx_s = TW'(i);
            end else begin
                hit_s     = hit_s;
            end
        end

        victim_dirty_s = valid_r[victim_ptr_r] & dirty_r[victim_ptr_r];
        if (hit_s) begin
            check_tag_s = hit_idx_s;
        end else begin
            check_tag_s = victim_ptr_r;
        end
        // cur_tag_r only becomes valid after CHECK, so use the fresh decision there
        if (state_r == CHECK) begin
            tag_nxt_s = check_tag_s;
        end else begin
            tag_nxt_s = cur_tag_r;
        end

        in_fetch_s = (state_r == WB_REQ) || (state_r == WB_WAIT) ||
                     (state_r == RF_REQ) || (state_r == RF_WAIT);
        dirty_ok_s = dirty_set && valid_r[dirty_tag] &&
                     !(in_fetch_s && (dirty_tag == cur_tag_r));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) state_nxt_s = CHECK;
                else           state_nxt_s = IDLE;
            end
            CHECK: begin
                if (hit_s)               state_nxt_s = RESP;
                else if (victim_dirty_s) state_nxt_s = WB_REQ;
                else                     state_nxt_s = RF_REQ;
            end
            WB_REQ: begin
                if (fetch_bus.fetch_gnt) state_nxt_s = WB_WAIT;
                else                     state_nxt_s = WB_REQ;
            end
            WB_WAIT: begin
                if (fetch_bus.fetch_done) state_nxt_s = RF_REQ;
                else                      state_nxt_s = WB_WAIT;
            end
            RF_REQ: begin
                if (fetch_bus.fetch_gnt) state_nxt_s = RF_WAIT;
                else                     state_nxt_s = RF_REQ;
            end
            RF_WAIT: begin
                if (fetch_bus.fetch_done) state_nxt_s = RESP;
                else                      state_nxt_s = RF_WAIT;
            end
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode: grants are combinational, the rest is precomputed from the next state
    always_comb begin
        miss_gnt_0   = (state_r == IDLE) && any_req_s && !win_s;
        miss_gnt_1   = (state_r == IDLE) && any_req_s && win_s;
        fetch_req_s  = 1'b0;
        fetch_cmd_s  = 2'b00;
        fetch_tag_s  = {TW{1'b0}};
        fetch_addr_s = {addr_width{1'b0}};
        done_0_s     = 1'b0;
        done_1_s     = 1'b0;
        miss_tag_s   = {TW{1'b0}};
        busy_s       = (state_nxt_s != IDLE);
        case (state_nxt_s)
            WB_REQ: begin
                fetch_req_s  = 1'b1;
                fetch_cmd_s  = CMD_WB;
                fetch_tag_s  = tag_nxt_s;
                fetch_addr_s = {line_tab_r[tag_nxt_s], {OW{1'b0}}};
            end
            RF_REQ: begin
                fetch_req_s  = 1'b1;
                fetch_cmd_s  = CMD_RF;
                fetch_tag_s  = tag_nxt_s;
                fetch_addr_s = {cur_line_r, {OW{1'b0}}};
            end
            RESP: begin
                done_0_s   = !owner_r;
                done_1_s   = owner_r;
                miss_tag_s = tag_nxt_s;
            end
            default: begin
                fetch_req_s = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_req_r  <= 1'b0;
            fetch_cmd_r  <= 2'b00;
            fetch_tag_r  <= {TW{1'b0}};
            fetch_addr_r <= {addr_width{1'b0}};
            done_0_r     <= 1'b0;
            done_1_r     <= 1'b0;
            miss_tag_r   <= {TW{1'b0}};
            busy_r       <= 1'b0;
        end else begin
            fetch_req_r  <= fetch_req_s;
            fetch_cmd_r  <= fetch_cmd_s;
            fetch_tag_r  <= fetch_tag_s;
            fetch_addr_r <= fetch_addr_s;
            done_0_r     <= done_0_s;
            done_1_r     <= done_1_s;
            miss_tag_r   <= miss_tag_s;
            busy_r       <= busy_s;
        end
    end

    // Miss context: owner, line address and round-robin pointer at grant, tag at CHECK
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_line_r <= {LW{1'b0}};
            owner_r    <= 1'b0;
            rr_ptr_r   <= 1'b0;
            cur_tag_r  <= {TW{1'b0}};
        end else begin
            if ((state_r == IDLE) && any_req_s) begin
                owner_r    <= win_s;
                rr_ptr_r   <= !win_s;
                cur_line_r <= win_s ? miss_addr_1[addr_width-1:OW] : miss_addr_0[addr_width-1:OW];
            end
            if (state_r == CHECK) begin
                cur_tag_r <= check_tag_s;
            end
        end
    end

    // Line table; later assignments win, so a dirty clear overrides a coincident set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r      <= {list_depth{1'b0}};
            dirty_r      <= {list_depth{1'b0}};
            victim_ptr_r <= {TW{1'b0}};
            for (int i = 0; i < list_depth; i++) begin
                line_tab_r[i] <= {LW{1'b0}};
            end
        end else begin
            if (dirty_ok_s) begin
                dirty_r[dirty_tag] <= 1'b1;
            end
            if ((state_r == WB_WAIT) && fetch_bus.fetch_done) begin
                dirty_r[cur_tag_r] <= 1'b0;
            end
            // the line stops being valid as soon as its refill is scheduled
            if ((state_nxt_s == RF_REQ) && (state_r != RF_REQ)) begin
                valid_r[tag_nxt_s] <= 1'b0;
            end
            if ((state_r == RF_WAIT) && fetch_bus.fetch_done) begin
                line_tab_r[cur_tag_r] <= cur_line_r;
                valid_r[cur_tag_r]    <= 1'b1;
                dirty_r[cur_tag_r]    <= 1'b0;
                if (victim_ptr_r == LAST_TAG) begin
                    victim_ptr_r <= {TW{1'b0}};
                end else begin
                    victim_ptr_r <= victim_ptr_r + {{(TW-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign fetch_bus.fetch_req  = fetch_req_r;
    assign fetch_bus.fetch_cmd  = fetch_cmd_r;
    assign fetch_bus.fetch_tag  = fetch_tag_r;
    assign fetch_bus.fetch_addr = fetch_addr_r;
    assign miss_done_0          = done_0_r;
    assign miss_done_1          = done_1_r;
    assign miss_tag             = miss_tag_r;
    assign line_valid           = valid_r;
    assign busy                 = busy_r;

endmodule

// File: tb/tb_line_miss_sched.sv
// Bench for line_miss_sched: a transaction-level line-table model predicts every
// output cycle by cycle; a negedge process compares; directed scenarios add
// literal checks on tags and addresses.
module tb_line_miss_sched;
    localparam int AW  = 32;
    localparam int LD  = 4;
    localparam int LWD = 32;

    logic        clk;
    logic        rst_n;
    logic        miss_req_0, miss_req_1;
    logic [31:0] miss_addr_0, miss_addr_1;
    logic        miss_gnt_0, miss_gnt_1, miss_done_0, miss_done_1;
    logic [1:0]  miss_tag;
    logic        dirty_set;
    logic [1:0]  dirty_tag;
    logic [3:0]  line_valid;
    logic        busy;

    line_miss_sched_if #(.addr_width(AW), .list_depth(LD)) fbus ();

    line_miss_sched #(.addr_width(AW), .list_depth(LD), .list_width(LWD)) dut (
        .clk(clk), .rst_n(rst_n),
        .miss_req_0(miss_req_0), .miss_req_1(miss_req_1),
        .miss_addr_0(miss_addr_0), .miss_addr_1(miss_addr_1),
        .miss_gnt_0(miss_gnt_0), .miss_gnt_1(miss_gnt_1),
        .miss_done_0(miss_done_0), .miss_done_1(miss_done_1),
        .miss_tag(miss_tag), .dirty_set(dirty_set), .dirty_tag(dirty_tag),
        .line_valid(line_valid), .busy(busy), .fetch_bus(fbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // model of the line table
    bit          m_valid [LD];
    bit          m_dirty [LD];
    logic [26:0] m_line  [LD];
    int          m_victim;
    int          m_rr;

    // expected outputs for the current cycle
    logic        chk_en;
    logic        e_gnt0, e_gnt1, e_done0, e_done1, e_busy, e_freq;
    logic [1:0]  e_cmd, e_ftag, e_tag;
    logic [31:0] e_faddr;
    logic [3:0]  e_valid;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] vvec();
        logic [3:0] v;
        for (int i = 0; i < LD; i++) v[i] = m_valid[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LD; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_line[i]  = 27'd0;
        end
        m_victim = 0;
        m_rr     = 0;
    endtask

    task automatic set_idle_exp();
        e_gnt0 = 1'b0; e_gnt1 = 1'b0; e_done0 = 1'b0; e_done1 = 1'b0;
        e_busy = 1'b0; e_freq = 1'b0; e_cmd = 2'b00; e_ftag = 2'b00;
        e_tag = 2'b00; e_faddr = 32'd0; e_valid = vvec();
    endtask

    task automatic compare_all();
        chk("miss_gnt_0", 64'(miss_gnt_0), 64'(e_gnt0));
        chk("miss_gnt_1", 64'(miss_gnt_1), 64'(e_gnt1));
        chk("miss_done_0", 64'(miss_done_0), 64'(e_done0));
        chk("miss_done_1", 64'(miss_done_1), 64'(e_done1));
        chk("line_valid", 64'(line_valid), 64'(e_valid));
        chk("busy", 64'(busy), 64'(e_busy));
        chk("fetch_req", 64'(fbus.fetch_req), 64'(e_freq));
        if (e_freq) begin
            chk("fetch_cmd", 64'(fbus.fetch_cmd), 64'(e_cmd));
            chk("fetch_tag", 64'(fbus.fetch_tag), 64'(e_ftag));
            chk("fetch_addr", 64'(fbus.fetch_addr), 64'(e_faddr));
        end
        if (e_done0 || e_done1) begin
            chk("miss_tag", 64'(miss_tag), 64'(e_tag));
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) compare_all();
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            miss_req_0 = 1'b0; miss_req_1 = 1'b0;
            set_idle_exp();
        end
    endtask

    task automatic set_dirty(input logic [1:0] tg);
        step();
        set_idle_exp();
        dirty_set = 1'b1; dirty_tag = tg;
        if (m_valid[tg]) m_dirty[tg] = 1'b1;
        step();
        dirty_set = 1'b0;
        set_idle_exp();
    endtask

    // One miss from grant cycle to RESP; returns the observed tag, owner and fetch addresses.
    task automatic miss_txn(input logic r0, input logic r1, input logic [31:0] a0,
                            input logic [31:0] a1, input int stall, input bit spur,
                            input bit dset, input bit rst_mid,
                            output logic [1:0] otag, output logic odone1,
                            output logic [31:0] orf, output logic [31:0] owb);
        int w, t;
        bit hit;
        logic [31:0] wa;
        logic [26:0] ln;
        otag = 2'b11; odone1 = 1'bx; orf = 32'hffff_ffff; owb = 32'hffff_ffff;
        step();
        miss_req_0 = r0; miss_req_1 = r1; miss_addr_0 = a0; miss_addr_1 = a1;
        if (r0 && r1) w = m_rr;
        else if (r1)  w = 1;
        else          w = 0;
        m_rr = 1 - w;
        wa = (w == 1) ? a1 : a0;
        ln = wa[31:5];
        set_idle_exp();
        e_gnt0 = (w == 0); e_gnt1 = (w == 1);
        step();                                   // CHECK
        if (w == 0) miss_req_0 = 1'b0; else miss_req_1 = 1'b0;
        e_gnt0 = 1'b0; e_gnt1 = 1'b0; e_busy = 1'b1;
        hit = 1'b0; t = m_victim;
        for (int i = 0; i < LD; i++) begin
            if (!hit && m_valid[i] && m_line[i] == ln) begin
                hit = 1'b1; t = i;
            end
        end
        if (!hit) begin
            if (m_valid[t] && m_dirty[t]) begin
                step();                           // writeback request
                e_freq = 1'b1; e_cmd = 2'b00; e_ftag = 2'(t); e_faddr = {m_line[t], 5'b00000};
                owb = fbus.fetch_addr;
                fbus.fetch_gnt = 1'b1;
                step();                           // writeback wait
                fbus.fetch_gnt = 1'b0; e_freq = 1'b0;
                step();
                fbus.fetch_done = 1'b1;
                m_dirty[t] = 1'b0;
            end
            step();                               // refill request
            fbus.fetch_done = 1'b0;
            m_valid[t] = 1'b0;
            e_valid = vvec(); e_freq = 1'b1; e_cmd = 2'b01; e_ftag = 2'(t);
            e_faddr = {ln, 5'b00000};
            orf = fbus.fetch_addr;
            for (int j = 0; j <= stall; j++) begin
                if (j > 0) step();
                fbus.fetch_gnt  = (j == stall);
                fbus.fetch_done = (spur && j == 1);
            end
            step();                               // refill wait
            fbus.fetch_gnt = 1'b0; fbus.fetch_done = 1'b0; e_freq = 1'b0;
            if (dset) begin
                dirty_set = 1'b1; dirty_tag = 2'(t);
            end
            if (rst_mid) begin
                #1;
                rst_n = 1'b0;
                miss_req_0 = 1'b0; miss_req_1 = 1'b0;
                model_reset();
                set_idle_exp();
                #1;
                compare_all();
                chk("rst_mid_fetch_addr", 64'(fbus.fetch_addr), 64'd0);
                chk("rst_mid_fetch_tag", 64'(fbus.fetch_tag), 64'd0);
                step();
                rst_n = 1'b1;
                return;
            end
            step();
            dirty_set = 1'b0;
            fbus.fetch_done = 1'b1;
            m_line[t] = ln; m_valid[t] = 1'b1; m_dirty[t] = 1'b0;
            m_victim = (m_victim + 1) % LD;
        end
        step();                                   // RESP
        fbus.fetch_done = 1'b0;
        e_valid = vvec(); e_freq = 1'b0;
        e_done0 = (w == 0); e_done1 = (w == 1); e_tag = 2'(t);
        otag = miss_tag; odone1 = miss_done_1;
    endtask

    logic [1:0]  otag;
    logic        od1;
    logic [31:0] orf, owb;

    initial begin
        rst_n = 1'b0; miss_req_0 = 1'b0; miss_req_1 = 1'b0;
        miss_addr_0 = 32'd0; miss_addr_1 = 32'd0; dirty_set = 1'b0; dirty_tag = 2'd0;
        fbus.fetch_gnt = 1'b0; fbus.fetch_done = 1'b0;
        chk_en = 1'b0;
        model_reset();
        set_idle_exp();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        chk("rst_fetch_cmd", 64'(fbus.fetch_cmd), 64'd0);
        chk("rst_fetch_tag", 64'(fbus.fetch_tag), 64'd0);
        chk("rst_fetch_addr", 64'(fbus.fetch_addr), 64'd0);
        chk("rst_miss_tag", 64'(miss_tag), 64'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // cold miss, port 0
        miss_txn(1'b1, 1'b0, 32'h0000_1040, 32'd0, 0, 1'b0, 1'b0, 1'b0, otag, od1, orf, owb);
        chk("cold_tag", 64'(otag), 64'd0);
        chk("cold_rf_addr", 64'(orf), 64'h1040);
        chk("cold_valid", 64'(line_valid), 64'h1);
        // hit merge, port 1
        miss_txn(1'b0, 1'b1, 32'd0, 32'h0000_1040, 0, 1'b0, 1'b0, 1'b0, otag, od1, orf, owb);
        chk("hit_tag", 64'(otag), 64'd0);
        chk("hit_port", 64'(od1), 64'd1);
        // fill lines 1..3
        miss_txn(1'b1, 1'b0, 32'h0000_1100, 32'd0, 1, 1'b0, 1'b0, 1'b0, otag, od1, orf, owb);
        miss_txn(1'b1, 1'b0, 32'h0000_1200, 32'd0, 0, 1'b0, 1'b0, 1'b0, otag, od1, orf, owb);
        miss_txn(1'b0, 1'b1, 32'd0, 32'h0000_1300, 0, 1'b0, 1'b0, 1'b0, otag, od1, orf, owb);
        chk("fill_tag", 64'(otag), 64'd3);
        chk("fill_valid", 64'(line_valid), 64'hf);
        // dirty eviction of line 0
        set_dirty(2'd0);
        miss_txn(1'b0, 1'b1, 32'd0, 32'h0000_2000, 2, 1'b0, 1'b0, 1'b0, otag, od1, orf, owb);
        chk("evict_wb_addr", 64'(owb), 64'h1040);
        chk("evict_rf_addr", 64'(orf), 64'h2000);
        chk("evict_tag", 64'(otag), 64'd0);
        // arbitration, stall, spurious done, dirty_set to cur_tag
        miss_txn(1'b1, 1'b1, 32'h0000_3000, 32'h0000_3100, 10, 1'b1, 1'b1, 1'b0, otag, od1, orf, owb);
        chk("arb1_port", 64'(od1), 64'd0);
        chk("arb1_tag", 64'(otag), 64'd1);
        miss_txn(1'b1, 1'b1, 32'h0000_3200, 32'h0000_3100, 0, 1'b0, 1'b0, 1'b0, otag, od1, orf, owb);
        chk("arb2_port", 64'(od1), 64'd1);
        chk("arb2_tag", 64'(otag), 64'd2);
        miss_txn(1'b0, 1'b1, 32'd0, 32'h0000_3300, 0, 1'b0, 1'b0, 1'b0, otag, od1, orf, owb);
        chk("arb3_port", 64'(od1), 64'd1);
        miss_txn(1'b1, 1'b1, 32'h0000_3400, 32'h0000_3500, 0, 1'b0, 1'b0, 1'b0, otag, od1, orf, owb);
        chk("arb4_port", 64'(od1), 64'd0);
        chk("arb4_tag", 64'(otag), 64'd0);
        miss_txn(1'b0, 1'b1, 32'd0, 32'h0000_3500, 0, 1'b0, 1'b0, 1'b0, otag, od1, orf, owb);
        chk("arb5_tag", 64'(otag), 64'd1);
        // reset in the middle of a refill, then a fresh miss
        miss_txn(1'b1, 1'b0, 32'h0000_5000, 32'd0, 0, 1'b0, 1'b0, 1'b1, otag, od1, orf, owb);
        miss_txn(1'b1, 1'b0, 32'h0000_6000, 32'd0, 0, 1'b0, 1'b0, 1'b0, otag, od1, orf, owb);
        chk("post_rst_tag", 64'(otag), 64'd0);
        chk("post_rst_valid", 64'(line_valid), 64'h1);
        idle_cycles(2);
        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/line_miss_sched.md
# line_miss_sched

Miss scheduler that sequences the line fetch engine on behalf of two cache-side requesters. It arbitrates miss requests round-robin and allocates a victim line with a FIFO pointer. For each miss it issues a writeback command (if the victim is valid and dirty) followed by a refill command. It keeps the per-line valid, dirty and line-address tables and returns the assigned line tag to the requester.

## Interface
- addr_width, 32, byte/word address width of miss and fetch addresses
- list_depth, 4, number of lines; tag width TW = $clog2(list_depth)
- list_width, 32, words per line; offset width OW = $clog2(list_width); line address = addr[addr_width-1:OW]
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- miss_req_0 / miss_req_1  in  1  miss request, held until granted
- miss_addr_0 / miss_addr_1  in  addr_width  miss address
- miss_gnt_0 / miss_gnt_1  out  1  request accepted (combinational, IDLE only)
- miss_done_0 / miss_done_1  out  1  one-cycle completion pulse to owner
- miss_tag  out  TW  line tag of completed miss, valid with miss_done_x
- dirty_set  in  1  cache write hit: mark line dirty
- dirty_tag  in  TW  line for dirty_set
- fetch_req  out  1  command request to fetch engine
- fetch_cmd  out  2  2'b00 writeback, 2'b01 refill
- fetch_tag  out  TW  line being written back / refilled
- fetch_addr  out  addr_width  line base address, low OW bits zero
- fetch_gnt  in  1  fetch engine accepts command
- fetch_done  in  1  one-cycle command completion pulse
- line_valid  out  list_depth  per-line valid vector
- busy  out  1  FSM not in IDLE

## Operation
- States: IDLE, CHECK, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT, RESP.
- IDLE: if any miss_req, grant exactly one. If both request, the port pointed to by rr_ptr wins, and rr_ptr then points to the other port. A single requester always wins, and rr_ptr then points away from it. Latch the line address and owner, then go to CHECK.
- CHECK (1 cycle): compare the latched line address against all lines where valid=1.
  - Hit: cur_tag = hit index; go to RESP with no fetch.
  - Miss: cur_tag = victim_ptr. Go to WB_REQ if valid[cur_tag] && dirty[cur_tag], else go to RF_REQ.
- WB_REQ: fetch_req=1, fetch_cmd=00, fetch_tag=cur_tag, fetch_addr={line_addr[cur_tag], OW'b0}. On fetch_req&&fetch_gnt go to WB_WAIT.
- WB_WAIT: on fetch_done clear dirty[cur_tag] and go to RF_REQ.
- RF_REQ: valid[cur_tag]=0 from state entry. fetch_req=1, fetch_cmd=01, fetch_addr={latched line addr, OW'b0}. On handshake go to RF_WAIT.
- RF_WAIT: on fetch_done set line_addr[cur_tag], valid=1, dirty=0; victim_ptr += 1 (wraps list_depth-1 to 0); go to RESP.
- RESP: miss_done_owner=1 and miss_tag=cur_tag for one cycle, then go to IDLE.
- dirty_set: sets dirty[dirty_tag] only if valid[dirty_tag]=1. It is ignored for cur_tag while in WB_REQ..RF_WAIT. When a clear and a set to the same line coincide, the clear wins.
- fetch_done outside WB_WAIT/RF_WAIT is ignored. fetch_req is held stable until the handshake.
- A miss_req arriving while busy is not granted and is not lost; the requester holds it.
- Reset, including mid-operation: FSM=IDLE, valid/dirty/line_addr all 0, victim_ptr=0, rr_ptr=port 0. An in-flight fetch is abandoned, and the fetch engine is reset by the same rst_n.

## Timing
- Every output resets to 0: fetch_req, fetch_cmd, fetch_tag, fetch_addr, miss_gnt_x, miss_done_x, miss_tag, line_valid, busy.
- Grant in cycle T (IDLE) → CHECK in T+1.
- Hit: miss_done in T+2.
- Clean miss: fetch_req rises in T+2.
- Dirty miss: fetch_req (cmd 00) rises in T+2. The refill fetch_req rises the cycle after fetch_done is sampled in WB_WAIT.
- fetch_done sampled in RF_WAIT at cycle N → miss_done at N+1, line_valid bit set at N+1.
- Earliest next grant is the cycle after RESP; back-to-back misses have a 1-cycle IDLE gap.
- All state is updated on the posedge of clk; only the miss_gnt_x outputs are combinational.

## Test plan
- Cold miss, port 0, addr 0x0000_1040:
  - Required fetch: refill, fetch_tag=0, fetch_addr=0x0000_1040 (OW=5 → base 0x1040 with low 5 bits 0). No writeback.
  - After fetch_done: miss_done_0=1, miss_tag=0, line_valid=4'b0001, victim_ptr=1.
- Hit merge:
  - Repeat 0x0000_1040 on port 1 → no fetch_req; miss_done_1 at T+2 with miss_tag=0.
- Dirty eviction:
  - Fill lines 0–3, then dirty_set tag 0.
  - Fifth miss at 0x2000 → writeback (cmd 00, tag 0, old line addr), then refill (cmd 01, tag 0, 0x2000). dirty[0]=0 and victim_ptr=1 afterwards.
- Arbitration:
  - miss_req_0 and miss_req_1 both held for 2 misses → grants go port 0, then port 1.
  - Port 1 alone, then both → port 0 wins.
- Stall and ignore:
  - Hold fetch_gnt=0 for 10 cycles → fetch_req and fetch_addr are stable throughout.
  - Spurious fetch_done in RF_REQ → ignored.
  - dirty_set to cur_tag during RF_WAIT → dirty stays 0.
- Reset mid-refill: assert rst_n=0 in RF_WAIT → all outputs 0 and line_valid=0 immediately; a fresh miss afterwards uses tag 0.
